seg_scan_driver: RTL

//  Time-multiplexed scan controller for the 8-digit 7-segment display.
//  - Snapshots the packed BCD/hex display word once per frame, then steps one digit per scan slot.
//  - Drives the active-low anodes.
//  - Feeds the per-digit nibble `num` and index `cdigit` to the downstream segment decoder.
//  - Inserts a blanking gap at the start of every slot to suppress ghosting.

---
 rtl/seg_scan_driver.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan controller for an up-to-8-digit 7-segment display.
// Optional blinking is built only when the SEG_BLINK_EN macro is defined.
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYC    = 1000,
    parameter int unsigned BLINK_FRAMES = 62
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    output logic [3:0]              num_o,
    output logic [3:0]              cdigit_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_done_o
);

    localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    if (SCAN_DIV < 2) begin : g_chk_div
        $error("seg_scan_driver: SCAN_DIV must be >= 2");
    end
    if (BLANK_CYC >= SCAN_DIV) begin : g_chk_blank
        $error("seg_scan_driver: BLANK_CYC must be < SCAN_DIV");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_chk_digits
        $error("seg_scan_driver: NUM_DIGITS must be 1..8");
    end
    if (BLINK_FRAMES < 1) begin : g_chk_blink
        $error("seg_scan_driver: BLINK_FRAMES must be >= 1");
    end

    logic [DivW-1:0]         div_cnt_q, div_cnt_d;
    logic [3:0]              cdigit_q, cdigit_d;
    logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [3:0]              num_q, num_d;
    logic                    frame_done_q;
    logic                    tick, frame_end, lit, hide;

    always_comb begin
        tick      = (div_cnt_q == DivW'(SCAN_DIV - 1));
        frame_end = tick && (cdigit_q == 4'(NUM_DIGITS - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        cdigit_d  = cdigit_q;
        if (tick) begin
            cdigit_d = frame_end ? 4'd0 : cdigit_q + 4'd1;
        end
        // Shadow copies only move at the frame boundary so a frame never tears.
        sh_data_d = frame_end ? data_i : sh_data_q;
        sh_en_d   = frame_end ? digit_en_i : sh_en_q;
    end

    // Outputs are registered from next-state so num, cdigit and an move together.
    always_comb begin
        dig_sel = '0;
        num_d   = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (cdigit_d == 4'(i)) begin
                dig_sel[i] = 1'b1;
                num_d      = sh_data_d[4*i +: 4];
            end
        end
        lit  = (|(dig_sel & sh_en_d)) && (div_cnt_d >= DivW'(BLANK_CYC)) && !hide;
        an_d = lit ? ~dig_sel : '1;
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned BlkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BlkW-1:0] blk_cnt_q, blk_cnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        phase_d   = phase_q;
        if (frame_end) begin
            if (blk_cnt_q == BlkW'(BLINK_FRAMES - 1)) begin
                blk_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
        // Mask is sampled live so blinking can be toggled mid-frame.
        hide = !phase_d && (|(dig_sel & blink_mask_i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
            phase_q   <= 1'b1;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
        end
    end
`else
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask_i;
    assign hide              = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            cdigit_q     <= '0;
            sh_data_q    <= '0;
            sh_en_q      <= '0;
            num_q        <= '0;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            cdigit_q     <= cdigit_d;
            sh_data_q    <= sh_data_d;
            sh_en_q      <= sh_en_d;
            num_q        <= num_d;
            an_q         <= an_d;
            frame_done_q <= frame_end;
        end
    end

    assign num_o        = num_q;
    assign cdigit_o     = cdigit_q;
    assign an_o         = an_q;
    assign frame_done_o = frame_done_q;

endmodule
